// File: rtl/time_keeper.sv
// time_keeper: HH:MM wall-clock time base with a two-button set mode and a blinking digit select.
// Define CLOCK_12H_EN for a 12-hour display (01..12) with an added pm output.
module time_keeper #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BLINK_DIV = CLK_HZ / 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic       sa,
    output logic       sb,
    output logic       sc,
    output logic       sd,
    output logic       sec_tick
`ifdef CLOCK_12H_EN
    ,
    output logic       pm
`endif
);
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);
`ifdef CLOCK_12H_EN
    localparam logic [3:0] HR_T_RST = 4'd1;
    localparam logic [3:0] HR_U_RST = 4'd2;
`else
    localparam logic [3:0] HR_T_RST = 4'd0;
    localparam logic [3:0] HR_U_RST = 4'd0;
`endif

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [5:0]    sec_q, sec_d;
    logic [3:0]    hr_t, hr_u, mn_t, mn_u;
    logic [3:0]    hr_t_d, hr_u_d, mn_t_d, mn_u_d;
    logic          phase_q, phase_d, blink_rst;
    logic          tick_d, sel_hr_q, sel_mn_q;
    logic [1:0]    mode_sync, inc_sync;
    logic          mode_prev, inc_prev, mode_edge, inc_edge;
    logic [3:0]    hr_t_inc, hr_u_inc, mn_t_inc, mn_u_inc;
    logic          mn_wrap;
`ifdef CLOCK_12H_EN
    logic          pm_q, pm_d, pm_flip;
`endif

    // Button synchronizers and rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync <= '0;
            inc_sync  <= '0;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[0], btn_mode};
            inc_sync  <= {inc_sync[0], btn_inc};
            mode_prev <= mode_sync[1];
            inc_prev  <= inc_sync[1];
        end
    end

    assign mode_edge = mode_sync[1] & ~mode_prev;
    assign inc_edge  = inc_sync[1] & ~inc_prev;

    // BCD increment of the hour and minute pairs, each wrapping within its own range
    always_comb begin
        hr_t_inc = hr_t;
        hr_u_inc = hr_u + 4'd1;
`ifdef CLOCK_12H_EN
        pm_flip = 1'b0;
        if (hr_t == 4'd1 && hr_u == 4'd2) begin
            hr_t_inc = 4'd0;
            hr_u_inc = 4'd1;
        end else if (hr_t == 4'd1 && hr_u == 4'd1) begin
            pm_flip = 1'b1;
        end else if (hr_u == 4'd9) begin
            hr_t_inc = 4'd1;
            hr_u_inc = 4'd0;
        end
`else
        if (hr_t == 4'd2 && hr_u == 4'd3) begin
            hr_t_inc = 4'd0;
            hr_u_inc = 4'd0;
        end else if (hr_u == 4'd9) begin
            hr_t_inc = hr_t + 4'd1;
            hr_u_inc = 4'd0;
        end
`endif
        mn_wrap  = (mn_t == 4'd5) && (mn_u == 4'd9);
        mn_u_inc = (mn_u == 4'd9) ? 4'd0 : mn_u + 4'd1;
        mn_t_inc = (mn_u != 4'd9) ? mn_t : (mn_t == 4'd5) ? 4'd0 : mn_t + 4'd1;
    end

    // Next-state, timekeeping and blink logic
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        sec_d     = sec_q;
        hr_t_d    = hr_t;
        hr_u_d    = hr_u;
        mn_t_d    = mn_t;
        mn_u_d    = mn_u;
        tick_d    = 1'b0;
        blink_rst = 1'b0;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
`ifdef CLOCK_12H_EN
        pm_d      = pm_q;
`endif
        case (state_q)
            RUN: begin
                if (presc_q == PRESC_TC) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d  = '0;
                        mn_t_d = mn_t_inc;
                        mn_u_d = mn_u_inc;
                        if (mn_wrap) begin
                            hr_t_d = hr_t_inc;
                            hr_u_d = hr_u_inc;
`ifdef CLOCK_12H_EN
                            pm_d   = pm_q ^ pm_flip;
`endif
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (mode_edge) begin
                    state_d   = SET_HOUR;
                    blink_rst = 1'b1;
                end
            end
            SET_HOUR: begin
                if (mode_edge) begin
                    state_d   = SET_MIN;
                    blink_rst = 1'b1;
                end else if (inc_edge) begin
                    hr_t_d    = hr_t_inc;
                    hr_u_d    = hr_u_inc;
`ifdef CLOCK_12H_EN
                    pm_d      = pm_q ^ pm_flip;
`endif
                    blink_rst = 1'b1;
                end
            end
            SET_MIN: begin
                if (mode_edge) begin
                    state_d = RUN;
                    presc_d = '0;
                    sec_d   = '0;
                end else if (inc_edge) begin
                    mn_t_d    = mn_t_inc;
                    mn_u_d    = mn_u_inc;
                    blink_rst = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (blink_rst) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q == BLINK_TC) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            presc_q  <= '0;
            sec_q    <= '0;
            hr_t     <= HR_T_RST;
            hr_u     <= HR_U_RST;
            mn_t     <= 4'd0;
            mn_u     <= 4'd0;
            bcnt_q   <= '0;
            phase_q  <= 1'b1;
            sec_tick <= 1'b0;
            sel_hr_q <= 1'b0;
            sel_mn_q <= 1'b0;
`ifdef CLOCK_12H_EN
            pm_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            hr_t     <= hr_t_d;
            hr_u     <= hr_u_d;
            mn_t     <= mn_t_d;
            mn_u     <= mn_u_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            sec_tick <= tick_d;
            sel_hr_q <= (state_d == SET_HOUR) & phase_d;
            sel_mn_q <= (state_d == SET_MIN) & phase_d;
`ifdef CLOCK_12H_EN
            pm_q     <= pm_d;
`endif
        end
    end

    assign a  = hr_t;
    assign b  = hr_u;
    assign c  = mn_t;
    assign d  = mn_u;
    assign sa = sel_hr_q;
    assign sb = sel_hr_q;
    assign sc = sel_mn_q;
    assign sd = sel_mn_q;
`ifdef CLOCK_12H_EN
    assign pm = pm_q;
`endif

endmodule
